// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Two-stage pipelined 8-bit ALU execute stage.
//   S1 registers the request (op, a, b). The ALU is combinational on S1.
//   S2 registers the result and the Z/C/N/V flags for writeback.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   request valid from issue
//   in_ready   stage can accept a request this cycle
//   op         000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA
//   a, b       operands; shifts use b[2:0] as the shift amount
//   out_valid  result valid (S2 occupied)
//   out_ready  writeback accepts the result
//   result     registered result
//   zf/cf/nf/vf registered zero, carry/borrow/shift-out, negative, overflow flags
//   op_count   number of results consumed, wraps at 16 bits
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds valid and its payload stable until the transfer; the
// consumer may raise or drop ready at will. in_ready is combinational from
// out_ready so a full pipe keeps streaming one op per cycle with no bubble.
// -----------------------------------------------------------------------------
module alu_exec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  result,
  output logic        zf,
  output logic        cf,
  output logic        nf,
  output logic        vf,
  output logic [15:0] op_count
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  // Stage 1 registers
  logic       s1_v;
  logic [2:0] s1_op;
  logic [7:0] s1_a;
  logic [7:0] s1_b;

  // Stage 2 valid; result and flags are the output registers themselves
  logic s2_v;

  logic s1_load;
  logic s2_load;
  logic consume;

  assign out_valid = s2_v;
  assign consume   = s2_v && out_ready;
  // S2 can take S1 when empty or when its current result leaves this cycle
  assign s2_load   = s1_v && (!s2_v || out_ready);
  assign in_ready  = !s1_v || s2_load;
  assign s1_load   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Combinational ALU on S1 contents
  // ---------------------------------------------------------------------------
  logic [7:0]  alu_res;
  logic        alu_c;
  logic        alu_v;
  logic [8:0]  wide;
  logic [15:0] sh_w;
  logic [2:0]  sh;

  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = 9'h000;
    sh_w    = 16'h0000;
    sh      = s1_b[2:0];
    case (s1_op)
      OP_ADD: begin
        wide    = {1'b0, s1_a} + {1'b0, s1_b};
        alu_res = wide[7:0];
        alu_c   = wide[8];
        alu_v   = (s1_a[7] == s1_b[7]) && (wide[7] != s1_a[7]);
      end
      OP_SUB: begin
        // Bit 8 of the 9-bit difference is the borrow (a < b unsigned)
        wide    = {1'b0, s1_a} - {1'b0, s1_b};
        alu_res = wide[7:0];
        alu_c   = wide[8];
        alu_v   = (s1_a[7] != s1_b[7]) && (wide[7] != s1_a[7]);
      end
      OP_AND: alu_res = s1_a & s1_b;
      OP_OR:  alu_res = s1_a | s1_b;
      OP_XOR: alu_res = s1_a ^ s1_b;
      OP_SLL: begin
        // Last bit shifted out lands at bit 8; zero when sh == 0
        sh_w    = {8'h00, s1_a} << sh;
        alu_res = sh_w[7:0];
        alu_c   = sh_w[8];
      end
      OP_SRL: begin
        // Last bit shifted out lands at bit 7 of the low byte
        sh_w    = {s1_a, 8'h00} >> sh;
        alu_res = sh_w[15:8];
        alu_c   = sh_w[7];
      end
      OP_SRA: begin
        sh_w    = 16'($signed({s1_a, 8'h00}) >>> sh);
        alu_res = sh_w[15:8];
        alu_c   = sh_w[7];
      end
      default: alu_res = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_op <= 3'b000;
      s1_a  <= 8'h00;
      s1_b  <= 8'h00;
    end else begin
      if (s1_load) begin
        s1_v  <= 1'b1;
        s1_op <= op;
        s1_a  <= a;
        s1_b  <= b;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: only written on s2_load, so a stalled result never changes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v   <= 1'b0;
      result <= 8'h00;
      zf     <= 1'b0;
      cf     <= 1'b0;
      nf     <= 1'b0;
      vf     <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_v   <= 1'b1;
        result <= alu_res;
        zf     <= (alu_res == 8'h00);
        cf     <= alu_c;
        nf     <= alu_res[7];
        vf     <= alu_v;
      end else if (consume) begin
        s2_v <= 1'b0;
      end
    end
  end

  // Consumed-result counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= 16'h0000;
    end else if (consume) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//   Self-checking bench for alu_exec_stage. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge. A monitor pushes the model's
// expected {result,zf,cf,nf,vf} for every accepted request and pops/compares
// on every consumed result.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  result;
  logic        zf;
  logic        cf;
  logic        nf;
  logic        vf;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];

  alu_exec_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zf        (zf),
    .cf        (cf),
    .nf        (nf),
    .vf        (vf),
    .op_count  (op_count)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Reference model: integer arithmetic, returns {result, zf, cf, nf, vf}
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x,
                                        input logic [7:0] y);
    int ai;
    int bi;
    int sa;
    int sb;
    int s;
    int r;
    logic [7:0] res;
    logic c;
    logic v;
    ai = int'(x);
    bi = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    s  = int'(y[2:0]);
    r  = 0;
    res = 8'h00;
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'd0: begin
        r = ai + bi; res = r[7:0]; c = (r > 255);
        v = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      3'd1: begin
        r = ai - bi; res = r[7:0]; c = (ai < bi);
        v = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      3'd2: res = x & y;
      3'd3: res = x | y;
      3'd4: res = x ^ y;
      3'd5: begin
        r = ai << s; res = r[7:0];
        c = (s > 0) ? (((ai >> (8 - s)) & 1) != 0) : 1'b0;
      end
      3'd6: begin
        r = ai >> s; res = r[7:0];
        c = (s > 0) ? (((ai >> (s - 1)) & 1) != 0) : 1'b0;
      end
      default: begin
        r = sa >>> s; res = r[7:0];
        c = (s > 0) ? (((ai >> (s - 1)) & 1) != 0) : 1'b0;
      end
    endcase
    return {res, (res == 8'h00), c, res[7], v};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_out got %h with no pending request",
                   {result, zf, cf, nf, vf});
        end else begin
          e = exp_q.pop_front();
          if ({result, zf, cf, nf, vf} !== e) begin
            errors++;
            $display("FAIL sb_data got %h exp %h", {result, zf, cf, nf, vf}, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end 1ns after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic rand_req();
    op = 3'($urandom_range(0, 7));
    a  = 8'($urandom_range(0, 255));
    b  = 8'($urandom_range(0, 255));
  endtask

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout in_ready never rose op=%0d", o);
    end
  endtask

  // Send one op with out_ready=1, check its flags inline and that it appears
  // on the second falling edge after acceptance (two-cycle latency).
  task automatic run_one(input string name, input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [11:0] exp);
    int n;
    logic got;
    out_ready = 1'b1;
    send(o, x, y);
    n = 0;
    got = 1'b0;
    while (!got && n < 5) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        checks++;
        if ({result, zf, cf, nf, vf} !== exp) begin
          errors++;
          $display("FAIL %s got %h exp %h", name, {result, zf, cf, nf, vf}, exp);
        end
        checks++;
        if (n !== 1) begin
          errors++;
          $display("FAIL %s_latency got %0d extra cycles exp 1", name, n);
        end
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout out_valid got 0 exp 1", name);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain pending got %0d out_valid %b exp 0 0", exp_q.size(), out_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenario tasks
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; a = 8'h00; b = 8'h00;
    #3;
    checks++;
    if ({out_valid, result, zf, cf, nf, vf, op_count} !== 29'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {out_valid, result, zf, cf, nf, vf, op_count});
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready %b out_valid %b exp 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sra();
    run_one("sra_96_3", 3'd7, 8'h96, 8'h03, {8'hF2, 4'b0110});
    run_one("sra_96_0", 3'd7, 8'h96, 8'h00, {8'h96, 4'b0010});
    run_one("sra_80_ff", 3'd7, 8'h80, 8'hFF, {8'hFF, 4'b0010});
  endtask

  task automatic test_arith();
    run_one("add_7f_01", 3'd0, 8'h7F, 8'h01, {8'h80, 4'b0011});
    run_one("add_ff_01", 3'd0, 8'hFF, 8'h01, {8'h00, 4'b1100});
    run_one("sub_00_01", 3'd1, 8'h00, 8'h01, {8'hFF, 4'b0110});
    run_one("sub_80_01", 3'd1, 8'h80, 8'h01, {8'h7F, 4'b0001});
    run_one("or_00_00", 3'd3, 8'h00, 8'h00, {8'h00, 4'b1000});
  endtask

  task automatic test_streaming();
    logic [2:0]  s_op[4];
    logic [7:0]  s_a[4];
    logic [7:0]  s_b[4];
    logic [11:0] s_exp[4];
    logic        ov_exp;
    s_op[0] = 3'd0; s_a[0] = 8'h12; s_b[0] = 8'h34; s_exp[0] = {8'h46, 4'b0000};
    s_op[1] = 3'd4; s_a[1] = 8'hF0; s_b[1] = 8'h0F; s_exp[1] = {8'hFF, 4'b0010};
    s_op[2] = 3'd5; s_a[2] = 8'h81; s_b[2] = 8'h01; s_exp[2] = {8'h02, 4'b0100};
    s_op[3] = 3'd6; s_a[3] = 8'h81; s_b[3] = 8'h01; s_exp[3] = {8'h40, 4'b0100};
    pulse_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      if (t < 4) begin
        in_valid = 1'b1; op = s_op[t]; a = s_a[t]; b = s_b[t];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (t < 4) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_in_ready t=%0d got %b exp 1", t, in_ready);
        end
      end
      ov_exp = (t >= 2 && t <= 5);
      checks++;
      if (out_valid !== ov_exp) begin
        errors++;
        $display("FAIL stream_out_valid t=%0d got %b exp %b", t, out_valid, ov_exp);
      end
      if (ov_exp) begin
        checks++;
        if ({result, zf, cf, nf, vf} !== s_exp[t-2]) begin
          errors++;
          $display("FAIL stream_data t=%0d got %h exp %h", t, {result, zf, cf, nf, vf}, s_exp[t-2]);
        end
      end
      if (t == 6) begin
        checks++;
        if (op_count !== 16'd4) begin
          errors++;
          $display("FAIL stream_op_count got %0d exp 4", op_count);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic took;
    logic held_set;
    logic [11:0] held;
    acc = 0;
    held_set = 1'b0;
    held = 12'h000;
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_req();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) acc++;
      if (out_valid) begin
        if (!held_set) begin
          held = {result, zf, cf, nf, vf};
          held_set = 1'b1;
        end else begin
          checks++;
          if ({result, zf, cf, nf, vf} !== held) begin
            errors++;
            $display("FAIL bp_stable got %h exp %h", {result, zf, cf, nf, vf}, held);
          end
        end
      end
      @(posedge clk); #1;
      if (took) rand_req();
    end
    checks++;
    if (acc !== 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_capacity accepts %0d in_ready %b out_valid %b exp 2 0 1",
               acc, in_ready, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_resume i=%0d out_valid %b in_ready %b exp 1 1", i, out_valid, in_ready);
      end
      @(posedge clk); #1;
      rand_req();
    end
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic took;
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_req();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_req();
      end
    end
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_midstream();
    int acc;
    int n;
    acc = 0;
    n = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_req();
    while (acc < 2 && n < 10) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      rand_req();
      n++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || op_count === 16'h0000) begin
      errors++;
      $display("FAIL mid_precond out_valid %b op_count %0d exp 1 nonzero", out_valid, op_count);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, result, zf, cf, nf, vf, op_count} !== 29'h0) begin
      errors++;
      $display("FAIL mid_reset got %h exp 0", {out_valid, result, zf, cf, nf, vf, op_count});
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release in_ready %b out_valid %b exp 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    run_one("mid_after", 3'd0, 8'h05, 8'h03, {8'h08, 4'b0000});
    wait_drain();
  endtask

  task automatic test_counter_wrap();
    int acc;
    int n;
    logic took;
    pulse_reset();
    out_ready = 1'b1;
    acc = 0;
    n = 0;
    in_valid = 1'b1;
    rand_req();
    while (acc < 65536 && n < 70000) begin
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) acc++;
      @(posedge clk); #1;
      if (acc == 65536) in_valid = 1'b0;
      else if (took) rand_req();
      n++;
    end
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (acc !== 65536 || op_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero accepts %0d op_count %h exp 65536 0000", acc, op_count);
    end
    run_one("wrap_next", 3'd2, 8'hF0, 8'h3C, {8'h30, 4'b0000});
    checks++;
    if (op_count !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_inc op_count got %h exp 0001", op_count);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_sra();
    test_arith();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
